// File: rtl/vregfile_inc_mp.sv
// Multi-port inc/stride register file: NUMRDPORTS registered reads, one write
// port (c), one read-modify-write update port (u). Reg 0 is hardwired to zero.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   a_reg/a_en/a_readdataout   packed read ports, 1-cycle latency, hold when idle
//   c_reg/c_writedatain/c_we   write port
//   u_reg/u_delta/u_en         update port: reg[u_reg] += u_delta
//   u_result/u_valid/u_conflict  update result, fresh pulse, dropped-by-write pulse
module vregfile_inc_mp #(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 8,
  parameter int LOG2NUMREGS = 3,
  parameter int NUMRDPORTS  = 2,
  parameter int BYPASS      = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUMRDPORTS*LOG2NUMREGS-1:0] a_reg,
  input  logic [NUMRDPORTS-1:0]             a_en,
  output logic [NUMRDPORTS*WIDTH-1:0]       a_readdataout,
  input  logic [LOG2NUMREGS-1:0]            c_reg,
  input  logic [WIDTH-1:0]                  c_writedatain,
  input  logic                              c_we,
  input  logic [LOG2NUMREGS-1:0]            u_reg,
  input  logic [WIDTH-1:0]                  u_delta,
  input  logic                              u_en,
  output logic [WIDTH-1:0]                  u_result,
  output logic                              u_valid,
  output logic                              u_conflict
);

  localparam int L = LOG2NUMREGS;

  logic [WIDTH-1:0] regs_q [NUMREGS];
  logic [WIDTH-1:0] regs_d [NUMREGS];

  logic [NUMRDPORTS*WIDTH-1:0] rdat_q, rdat_d;
  logic [WIDTH-1:0]            u_result_q, u_result_d;
  logic                        u_valid_q, u_valid_d;
  logic                        u_conflict_q, u_conflict_d;

  logic             c_hit, u_hit, conflict;
  logic [WIDTH-1:0] u_op, u_sum;

  // Storage-backed address: nonzero and inside the implemented depth.
  function automatic logic live(input logic [L-1:0] a);
    return (a != '0) && (32'(a) < 32'(NUMREGS));
  endfunction

  always_comb begin
    regs_d   = regs_q;
    c_hit    = c_we && live(c_reg);
    conflict = c_hit && u_en && (u_reg == c_reg);
    u_hit    = u_en && !conflict && live(u_reg);
    u_op     = live(u_reg) ? regs_q[u_reg] : '0;
    u_sum    = u_op + u_delta;

    // c and u never target the same reg here: that case is a conflict.
    if (u_hit) regs_d[u_reg] = u_sum;
    if (c_hit) regs_d[c_reg] = c_writedatain;

    rdat_d = rdat_q;
    for (int i = 0; i < NUMRDPORTS; i++) begin
      if (a_en[i]) begin
        if (!live(a_reg[i*L +: L]))
          rdat_d[i*WIDTH +: WIDTH] = '0;
        else if (BYPASS != 0)
          rdat_d[i*WIDTH +: WIDTH] = regs_d[a_reg[i*L +: L]];
        else
          rdat_d[i*WIDTH +: WIDTH] = regs_q[a_reg[i*L +: L]];
      end
    end

    u_result_d   = u_result_q;
    u_valid_d    = u_en && !conflict;
    u_conflict_d = conflict;
    if (u_valid_d) u_result_d = u_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUMREGS; k++) regs_q[k] <= '0;
      rdat_q       <= '0;
      u_result_q   <= '0;
      u_valid_q    <= 1'b0;
      u_conflict_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUMREGS; k++) regs_q[k] <= regs_d[k];
      rdat_q       <= rdat_d;
      u_result_q   <= u_result_d;
      u_valid_q    <= u_valid_d;
      u_conflict_q <= u_conflict_d;
    end
  end

  assign a_readdataout = rdat_q;
  assign u_result      = u_result_q;
  assign u_valid       = u_valid_q;
  assign u_conflict    = u_conflict_q;

endmodule
